// File: rtl/gcm_result_capture_if.sv
// gcm_result_capture_if
// Word stream from the GCM core into the result capture block.
//   in_valid : word on in_data is valid
//   in_data  : 32-bit result word; word 0 is the most significant
//   in_last  : final word of the result, qualified by in_valid && in_ready
//   in_ready : capture block accepts a word this cycle
// Handshake: a word transfers on every rising clk edge where
// in_valid && in_ready are both high. in_last has meaning only on that edge.
interface gcm_result_capture_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/gcm_result_capture.sv
// gcm_result_capture
// Collects a 128-bit GCM result as four 32-bit words, measures the latency
// from start to the last word, and holds the committed value and the count
// for the seven-segment display driver downstream.
// Ports:
//   clk, clr    : clock; asynchronous active-high reset
//   start       : one-cycle pulse, begins a measurement from any state
//   in_if       : word stream (slave side), see gcm_result_capture_if
//   o_x         : committed 128-bit result, bit 0 is the MSB
//   o_count     : latency count, saturates at TIMEOUT
//   o_done      : a result is committed
//   o_busy      : measurement in progress
//   o_dbg_state : current FSM state (IDLE=0, RUN=1, DONE=2, TOUT=3)
module gcm_result_capture #(
    parameter logic [31:0] TIMEOUT = 32'h3B9A_CA00
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    gcm_result_capture_if.slave  in_if,
    output logic [0:127]         o_x,
    output logic [0:31]          o_count,
    output logic                 o_done,
    output logic                 o_busy,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, TOUT = 2'd3} state_t;

    state_t       state_q, state_d;
    logic [0:127] x_q, x_d;
    logic [0:127] shadow_q, shadow_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [1:0]   idx_q, idx_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;

    logic         accept;
    logic         complete;
    logic [31:0]  cnt_inc;
    logic [6:0]   word_base;
    logic [0:127] merged;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        done_d   = done_q;

        // Start outranks any word on the same cycle, so accept is masked.
        accept    = (state_q == RUN) && in_if.in_valid && !start;
        complete  = accept && ((idx_q == 2'd3) || in_if.in_last);
        cnt_inc   = (cnt_q >= TIMEOUT) ? TIMEOUT : cnt_q + 32'd1;
        word_base = {idx_q, 5'd0};

        // Shadow with the current word dropped in; words not yet written are
        // still zero because start clears the shadow.
        merged = shadow_q;
        merged[word_base +: 32] = in_if.in_data;

        if (start) begin
            state_d  = RUN;
            cnt_d    = 32'd0;
            idx_d    = 2'd0;
            shadow_d = '0;
            done_d   = 1'b0;
        end else if (state_q == RUN) begin
            cnt_d = cnt_inc;
            if (accept) begin
                shadow_d = merged;
                idx_d    = idx_q + 2'd1;
            end
            if (complete) begin
                // Completion wins over the timeout threshold on the same cycle.
                x_d     = merged;
                done_d  = 1'b1;
                state_d = DONE;
            end else if (cnt_q == TIMEOUT - 32'd1) begin
                cnt_d   = TIMEOUT;
                state_d = TOUT;
            end
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            x_q      <= '0;
            shadow_q <= '0;
            cnt_q    <= 32'd0;
            idx_q    <= 2'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign in_if.in_ready = (state_q == RUN);
    assign o_x            = x_q;
    assign o_count        = cnt_q;
    assign o_done         = done_q;
    assign o_busy         = busy_q;
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_gcm_result_capture.sv
module tb_gcm_result_capture;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic [0:127] o_x;
  logic [0:31]  o_count;
  logic         o_done;
  logic         o_busy;
  logic [1:0]   o_dbg_state;

  gcm_result_capture_if bus ();

  gcm_result_capture #(.TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .start(start), .in_if(bus),
    .o_x(o_x), .o_count(o_count), .o_done(o_done), .o_busy(o_busy),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: list of accepted words, a running flag and an
  // integer latency counter.
  logic         m_run;
  logic         m_done;
  int           m_count;
  logic [127:0] m_x;
  logic [31:0]  m_words[$];

  typedef struct {
    logic        st;
    logic        v;
    logic [31:0] d;
    logic        l;
    int          exp_cnt;
    logic        exp_done;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_done = 1'b0; m_count = 0; m_x = '0;
    m_words.delete();
  endtask

  task automatic model_step(input logic st, input logic v, input logic [31:0] d, input logic l);
    bit fin;
    fin = 1'b0;
    if (st) begin
      m_words.delete(); m_count = 0; m_done = 1'b0; m_run = 1'b1;
    end else if (m_run) begin
      m_count = (m_count + 1 > TO) ? TO : m_count + 1;
      if (v) begin
        m_words.push_back(d);
        if (m_words.size() == 4 || l) fin = 1'b1;
      end
      if (fin) begin
        m_x = '0;
        foreach (m_words[i]) m_x[127 - 32*i -: 32] = m_words[i];
        m_done = 1'b1; m_run = 1'b0;
      end else if (m_count == TO) begin
        m_run = 1'b0;
      end
    end
  endtask

  task automatic chk_model();
    chk("o_x", o_x, m_x);
    chk("o_count", 128'(o_count), 128'(m_count));
    chk("o_done", 128'(o_done), 128'(m_done));
    chk("o_busy", 128'(o_busy), 128'(m_run));
  endtask

  // driver: called at posedge+1; applies one cycle of inputs
  task automatic cycle(input logic st, input logic v, input logic [31:0] d, input logic l);
    start = st; bus.in_valid = v; bus.in_data = d; bus.in_last = l;
    #1;
    chk("in_ready", 128'(bus.in_ready), 128'(m_run));
    @(posedge clk);
    model_step(st, v, d, l);
    #1;
    start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  logic [31:0] w[4];

  initial begin
    clr = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    model_reset();
    w[0] = 32'h2B7E1516; w[1] = 32'h28AED2A6; w[2] = 32'hABF71588; w[3] = 32'h09CF4F3C;

    #12;
    chk("reset_o_x", o_x, 128'h0);
    chk("reset_o_count", 128'(o_count), 128'h0);
    chk("reset_flags", {125'h0, o_done, o_busy, bus.in_ready}, 128'h0);
    clr = 1'b0;
    @(posedge clk); #1;

    // Nominal transfer, table-driven
    tbl[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 0, 1'b0};
    for (int i = 0; i < 4; i++) tbl[i+1] = '{1'b0, 1'b1, w[i], 1'b0, i + 1, (i == 3)};
    for (int i = 0; i < 5; i++) begin
      cycle(tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].l);
      chk($sformatf("nominal_cnt_%0d", i), 128'(o_count), 128'(tbl[i].exp_cnt));
      chk($sformatf("nominal_done_%0d", i), 128'(o_done), 128'(tbl[i].exp_done));
    end
    chk("nominal_x", o_x, 128'h2B7E151628AED2A6ABF7158809CF4F3C);
    #1 chk("nominal_ready_low", 128'(bus.in_ready), 128'h0);
    idle(2);
    chk("done_frozen_cnt", 128'(o_count), 128'd4);

    // Backpressure gaps of 3 cycles
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) idle(3);
      cycle(1'b0, 1'b1, w[i], 1'b0);
    end
    chk("bp_cnt", 128'(o_count), 128'd13);
    chk("bp_x", o_x, 128'h2B7E151628AED2A6ABF7158809CF4F3C);

    // Early in_last
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    cycle(1'b0, 1'b1, 32'h01234567, 1'b1);
    chk("last_x", o_x, 128'hDEADBEEF012345670000000000000000);
    chk("last_done", 128'(o_done), 128'h1);

    // Timeout with one word only
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h55555555, 1'b0);
    idle(20);
    chk("tout_cnt", 128'(o_count), 128'd16);
    chk("tout_x", o_x, 128'hDEADBEEF012345670000000000000000);
    chk("tout_done", 128'(o_done), 128'h0);
    chk("tout_state", 128'(o_dbg_state), 128'd3);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    chk("tout_restart_cnt", 128'(o_count), 128'd0);

    // Restart at idx==2 with a word on the start cycle
    cycle(1'b0, 1'b1, 32'h11111111, 1'b0);
    cycle(1'b0, 1'b1, 32'h22222222, 1'b0);
    cycle(1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, w[3-i], 1'b0);
    chk("restart_x", o_x, 128'h09CF4F3CABF7158828AED2A62B7E1516);
    chk("restart_cnt", 128'(o_count), 128'd4);

    // Completion on the threshold cycle
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    idle(15);
    cycle(1'b0, 1'b1, 32'hCAFEF00D, 1'b1);
    chk("thresh_cnt", 128'(o_count), 128'd16);
    chk("thresh_state", 128'(o_dbg_state), 128'd2);
    chk("thresh_x", o_x, 128'hCAFEF00D000000000000000000000000);

    // Async reset between edges in RUN
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h12345678, 1'b0);
    #3 clr = 1'b1;
    #1;
    chk("areset_o_x", o_x, 128'h0);
    chk("areset_o_count", 128'(o_count), 128'h0);
    chk("areset_flags", {125'h0, o_done, o_busy, bus.in_ready}, 128'h0);
    clr = 1'b0;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
    chk("no_accept_x", o_x, 128'h0);

    // Randomized stimulus against the reference model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
            $urandom(), ($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
